// File: rtl/dtmr_sched_pkg.sv
// Purpose: shared definitions for the dynamic-TMR scheduler and its voter (FSM encodings, replica bit indices).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dtmr_sched_pkg;

    // Scheduler FSM encodings; the voter decodes the same values.
    typedef enum logic [2:0] {
        ST_SIMPLEX  = 3'd0,
        ST_WARMUP   = 3'd1,
        ST_TMR      = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_RESYNC   = 3'd4,
        ST_FAILSAFE = 3'd5
    } state_t;

    // Bit positions of each replica inside fault / mod_en / mod_rst / mod_fail.
    localparam int REP1 = 2;
    localparam int REP2 = 1;
    localparam int REP3 = 0;

    // Replica enable and reset patterns.
    localparam logic [2:0] EN_SIMPLEX = 3'b100;  // replica1 only
    localparam logic [2:0] EN_ALL     = 3'b111;
    localparam logic [2:0] RST_WARMUP = 3'b011;  // replicas 2 and 3 restart from a clean state

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    function automatic logic [2:0] rep_bit(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/dtmr_sched_persist_cnt.sv
// Purpose: saturating persistence counter; counts consecutive cycles of a condition, flags when MAX is reached.
// Latency: hit is combinational from inc/clr and reflects the count including the current cycle.
// Backpressure: none; a low inc clears the count, clr forces and holds it at zero.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       hold the counter at zero (overrides inc)
//   inc       condition present this cycle
//   hit       count including this cycle has reached MAX
module persist_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        if (!clr && inc) begin
            cnt_nxt = (cnt == MAX_VAL) ? cnt : cnt + WIDTH'(1);
        end
    end

    // Looking at the next value lets the scheduler act on the MAX-th flagged
    // cycle itself rather than one cycle later.
    assign hit = (cnt_nxt == MAX_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dtmr_sched.sv
// Purpose: dynamic-TMR mode scheduler; powers replicas, filters voter faults, recovers/retires replicas, raises alarm.
// Latency: every output is registered; a decision on cycle n inputs is visible on cycle n+1.
// Backpressure: none; tmr_req is a level request and fault is sampled every cycle.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   tmr_req     level request for protected (voting) operation
//   fault[2:0]  voter fault flags, [2]=replica1 [1]=replica2 [0]=replica3
//   dtmr_state  voter mode: 1 = voting, 0 = pass replica1
//   mod_en      replica enables (same bit order as fault)
//   mod_rst     replica resets (same bit order as fault)
//   mod_fail    sticky per-replica "out of retries"
//   alarm       sticky, set on entering FAILSAFE
//   rec_total   recoveries performed, saturating at 255
module dtmr_sched
    import dtmr_sched_pkg::*;
#(
    parameter int WARMUP_CYC    = 8,
    parameter int FAULT_PERSIST = 4,
    parameter int RECOVER_CYC   = 16,
    parameter int HOLD_CYC      = 64,
    parameter int MAX_RETRY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tmr_req,
    input  logic [2:0] fault,
    output logic       dtmr_state,
    output logic [2:0] mod_en,
    output logic [2:0] mod_rst,
    output logic [2:0] mod_fail,
    output logic       alarm,
    output logic [7:0] rec_total
);

    localparam int PH_MAX = (WARMUP_CYC > RECOVER_CYC) ? WARMUP_CYC : RECOVER_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IDLE_W = $clog2(HOLD_CYC + 1);
    localparam int PC_W   = $clog2(FAULT_PERSIST + 1);

    localparam logic [PH_W-1:0]   WARMUP_LAST  = PH_W'(WARMUP_CYC - 1);
    localparam logic [PH_W-1:0]   RECOVER_LAST = PH_W'(RECOVER_CYC - 1);
    localparam logic [IDLE_W-1:0] HOLD_VAL     = IDLE_W'(HOLD_CYC);
    localparam logic [1:0]        RETRY_MAX    = 2'(MAX_RETRY);

    state_t            state;
    logic [PH_W-1:0]   phase;        // cycles spent in WARMUP / RECOVER / RESYNC
    logic [IDLE_W-1:0] idle;
    logic [IDLE_W-1:0] idle_nxt;
    logic [1:0]        tgt;          // replica under recovery
    logic [1:0]        retry [0:2];  // recoveries granted per replica, indexed by fault bit

    logic       in_rec;
    logic [2:0] fault_m;
    logic       cnt_clr;
    logic [2:0] sc_inc;
    logic [2:0] sc_hit;
    logic       mc_inc;
    logic       mc_hit;
    logic       any_hit;
    logic       idle_hit;
    logic [1:0] hit_idx;

    assign in_rec = (state == ST_RECOVER) || (state == ST_RESYNC);

    // The replica being recovered is held in reset and then resynchronising,
    // so its own flag says nothing about the health of the other two.
    assign fault_m = in_rec ? (fault & ~rep_bit(tgt)) : fault;

    // Counters only mean something while voting; they also restart from zero
    // when a resync completes so stale history cannot trigger a second action.
    assign cnt_clr = (state == ST_SIMPLEX) || (state == ST_WARMUP) || (state == ST_FAILSAFE) ||
                     ((state == ST_RESYNC) && (phase == WARMUP_LAST));

    for (genvar i = 0; i < 3; i++) begin : g_sc
        assign sc_inc[i] = (fault_m == rep_bit(2'(i)));

        persist_cnt #(
            .WIDTH (PC_W),
            .MAX   (FAULT_PERSIST)
        ) u_sc (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (sc_inc[i]),
            .hit (sc_hit[i])
        );
    end

    assign mc_inc = (popcnt3(fault_m) >= 2'd2);

    persist_cnt #(
        .WIDTH (PC_W),
        .MAX   (FAULT_PERSIST)
    ) u_mc (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (mc_inc),
        .hit (mc_hit)
    );

    assign any_hit = |sc_hit;

    // Single-fault hits are one-hot by construction; the priority only fixes
    // a deterministic encoding.
    always_comb begin
        hit_idx = 2'(REP3);
        if (sc_hit[REP1]) begin
            hit_idx = 2'(REP1);
        end else if (sc_hit[REP2]) begin
            hit_idx = 2'(REP2);
        end
    end

    // Quiet time in TMR: no request and no flag at all.
    always_comb begin
        idle_nxt = '0;
        if ((state == ST_TMR) && !tmr_req && (fault == 3'b000)) begin
            idle_nxt = (idle == HOLD_VAL) ? idle : idle + IDLE_W'(1);
        end
    end

    assign idle_hit = (state == ST_TMR) && (idle_nxt == HOLD_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SIMPLEX;
            phase      <= '0;
            idle       <= '0;
            tgt        <= '0;
            for (int i = 0; i < 3; i++) begin
                retry[i] <= '0;
            end
            dtmr_state <= 1'b0;
            mod_en     <= EN_SIMPLEX;
            mod_rst    <= 3'b000;
            mod_fail   <= 3'b000;
            alarm      <= 1'b0;
            rec_total  <= 8'd0;
        end else begin
            idle <= idle_nxt;

            case (state)
                ST_SIMPLEX: begin
                    if (tmr_req) begin
                        state   <= ST_WARMUP;
                        phase   <= '0;
                        mod_en  <= EN_ALL;
                        mod_rst <= RST_WARMUP;
                    end
                end

                ST_WARMUP: begin
                    // Reset pulse on the freshly powered replicas lasts one cycle.
                    mod_rst <= 3'b000;
                    if (phase == WARMUP_LAST) begin
                        state      <= ST_TMR;
                        phase      <= '0;
                        dtmr_state <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                ST_TMR: begin
                    if (mc_hit) begin
                        state      <= ST_FAILSAFE;
                        dtmr_state <= 1'b1;
                        mod_en     <= EN_ALL;
                        mod_rst    <= 3'b000;
                        alarm      <= 1'b1;
                    end else if (any_hit) begin
                        if (retry[hit_idx] == RETRY_MAX) begin
                            // Replica keeps failing after its allowed recoveries:
                            // retire it and stop trusting the vote.
                            mod_fail[hit_idx] <= 1'b1;
                            state             <= ST_FAILSAFE;
                            dtmr_state        <= 1'b1;
                            mod_en            <= EN_ALL;
                            mod_rst           <= 3'b000;
                            alarm             <= 1'b1;
                        end else begin
                            state          <= ST_RECOVER;
                            phase          <= '0;
                            tgt            <= hit_idx;
                            mod_rst        <= rep_bit(hit_idx);
                            retry[hit_idx] <= retry[hit_idx] + 2'd1;
                            if (rec_total != 8'hFF) begin
                                rec_total <= rec_total + 8'd1;
                            end
                        end
                    end else if (idle_hit) begin
                        state      <= ST_SIMPLEX;
                        dtmr_state <= 1'b0;
                        mod_en     <= EN_SIMPLEX;
                    end
                end

                ST_RECOVER, ST_RESYNC: begin
                    // Voting continues on the two healthy replicas; if one of
                    // them also goes bad there is no majority left.
                    if (mc_hit || any_hit) begin
                        state      <= ST_FAILSAFE;
                        dtmr_state <= 1'b1;
                        mod_en     <= EN_ALL;
                        mod_rst    <= 3'b000;
                        alarm      <= 1'b1;
                    end else if ((state == ST_RECOVER) && (phase == RECOVER_LAST)) begin
                        state   <= ST_RESYNC;
                        phase   <= '0;
                        mod_rst <= 3'b000;
                    end else if ((state == ST_RESYNC) && (phase == WARMUP_LAST)) begin
                        state <= ST_TMR;
                        phase <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                ST_FAILSAFE: begin
                    dtmr_state <= 1'b1;
                    mod_en     <= EN_ALL;
                    mod_rst    <= 3'b000;
                    alarm      <= 1'b1;
                end

                default: begin
                    // Unused encodings fall into the safe state.
                    state      <= ST_FAILSAFE;
                    dtmr_state <= 1'b1;
                    mod_en     <= EN_ALL;
                    mod_rst    <= 3'b000;
                    alarm      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtmr_sched.sv
// Purpose: self-checking bench for dtmr_sched; expected output changes are queued with their cycle stamps.
// Latency: a monitor compares every observed output change against the head of the queue.
// Backpressure: n/a.
module tb_dtmr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tmr_req;
    logic [2:0] fault;
    logic       dtmr_state;
    logic [2:0] mod_en;
    logic [2:0] mod_rst;
    logic [2:0] mod_fail;
    logic       alarm;
    logic [7:0] rec_total;

    dtmr_sched dut (
        .clk        (clk),
        .rst        (rst),
        .tmr_req    (tmr_req),
        .fault      (fault),
        .dtmr_state (dtmr_state),
        .mod_en     (mod_en),
        .mod_rst    (mod_rst),
        .mod_fail   (mod_fail),
        .alarm      (alarm),
        .rec_total  (rec_total)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ds;
        logic [2:0] en;
        logic [2:0] rs;
        logic [2:0] fl;
        logic       al;
        logic [7:0] rt;
    } obs_t;

    typedef struct {
        int    cyc;
        obs_t  v;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_run = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    bit   first_obs = 1'b1;
    bit   chk_end = 1'b0;
    bit   end_done = 1'b0;
    obs_t last_obs;
    obs_t obs;
    exp_t e;

    function automatic obs_t mk(input logic ds, input logic [2:0] en, input logic [2:0] rs,
                                input logic [2:0] fl, input logic al, input logic [7:0] rt);
        obs_t o;
        o.ds = ds; o.en = en; o.rs = rs; o.fl = fl; o.al = al; o.rt = rt;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ds=%0b en=%b rs=%b fail=%b al=%0b rt=%0d", o.ds, o.en, o.rs, o.fl, o.al, o.rt);
    endfunction

    task automatic push_exp(input int off, input obs_t v, input string nm);
        exp_t x;
        x.cyc  = cyc + off;
        x.v    = v;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Inputs driven now are sampled on the next rising edge.
    task automatic drive(input logic r, input logic [2:0] f, input int n);
        tmr_req = r;
        fault   = f;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From SIMPLEX: one-cycle request, then 8 warmup cycles (warmup faults ignored).
    task automatic enter_tmr(input logic [2:0] wf, input logic [2:0] fl, input logic [7:0] rt);
        push_exp(1, mk(1'b0, 3'b111, 3'b011, fl, 1'b0, rt), "warmup_entry");
        push_exp(2, mk(1'b0, 3'b111, 3'b000, fl, 1'b0, rt), "warmup_rst_release");
        push_exp(9, mk(1'b1, 3'b111, 3'b000, fl, 1'b0, rt), "tmr_entry");
        drive(1'b1, wf, 1);
        drive(1'b0, wf, 8);
    endtask

    task automatic do_reset(input string nm);
        push_exp(1, mk(1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 8'd0), nm);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1);
        rst = 1'b0;
        drive(1'b0, 3'b000, 2);
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_on) begin
            obs = mk(dtmr_state, mod_en, mod_rst, mod_fail, alarm, rec_total);
            if (first_obs || (obs !== last_obs)) begin
                first_obs = 1'b0;
                last_obs  = obs;
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cyc %0d got %s, required no change", cyc, fmt(obs));
                end else begin
                    e = exp_q.pop_front();
                    if ((obs !== e.v) || (cyc != e.cyc)) begin
                        n_fail++;
                        $display("FAIL %s: got %s at cyc %0d, required %s at cyc %0d",
                                 e.name, fmt(obs), cyc, fmt(e.v), e.cyc);
                    end
                end
            end
            if (chk_end && !end_done) begin
                end_done = 1'b1;
                n_run++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing_events: %0d expected changes not seen, first %s at cyc %0d",
                             exp_q.size(), exp_q[0].name, exp_q[0].cyc);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        tmr_req = 1'b0;
        fault   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        push_exp(0, mk(1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 8'd0), "reset_state");
        mon_on = 1'b1;
        rst    = 1'b0;

        // 1: idle in SIMPLEX, nothing may change.
        drive(1'b0, 3'b000, 20);

        // 2: warmup, TMR, then 64 quiet TMR cycles back to SIMPLEX.
        enter_tmr(3'b000, 3'b000, 8'd0);
        push_exp(64, mk(1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 8'd0), "hold_to_simplex");
        drive(1'b0, 3'b000, 70);

        // 3: replica2 persistent fault -> 16-cycle recovery, masked flag during resync.
        enter_tmr(3'b000, 3'b000, 8'd0);
        push_exp(4,  mk(1'b1, 3'b111, 3'b010, 3'b000, 1'b0, 8'd1), "recover_rep2");
        push_exp(20, mk(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 8'd1), "resync_rep2");
        drive(1'b0, 3'b010, 4);
        drive(1'b0, 3'b000, 16);
        drive(1'b0, 3'b010, 8);

        // 4: broken fault runs (3, gap, 3) never recover; TMR then times out.
        drive(1'b0, 3'b010, 3);
        drive(1'b0, 3'b000, 1);
        drive(1'b0, 3'b010, 3);
        push_exp(64, mk(1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 8'd1), "hold_after_resync");
        drive(1'b0, 3'b000, 70);

        // 5: replica3 fails three times: two recoveries then retirement.
        enter_tmr(3'b111, 3'b000, 8'd1);
        push_exp(4,  mk(1'b1, 3'b111, 3'b001, 3'b000, 1'b0, 8'd2), "recover_rep3_a");
        push_exp(20, mk(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 8'd2), "resync_rep3_a");
        drive(1'b0, 3'b001, 4);
        drive(1'b0, 3'b000, 24);
        push_exp(4,  mk(1'b1, 3'b111, 3'b001, 3'b000, 1'b0, 8'd3), "recover_rep3_b");
        push_exp(20, mk(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 8'd3), "resync_rep3_b");
        drive(1'b0, 3'b001, 4);
        drive(1'b0, 3'b000, 24);
        push_exp(4,  mk(1'b1, 3'b111, 3'b000, 3'b001, 1'b1, 8'd3), "rep3_retired");
        drive(1'b0, 3'b001, 4);
        drive(1'b1, 3'b111, 20);
        do_reset("reset_from_failsafe");

        // 6a: multi-fault persistence -> FAILSAFE.
        enter_tmr(3'b000, 3'b000, 8'd0);
        push_exp(4, mk(1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 8'd0), "multi_fault_alarm");
        drive(1'b0, 3'b111, 4);
        drive(1'b1, 3'b101, 10);
        do_reset("reset_after_alarm");

        // 6b: fault beats a simultaneous request; reset aborts a recovery.
        enter_tmr(3'b000, 3'b000, 8'd0);
        push_exp(4, mk(1'b1, 3'b111, 3'b100, 3'b000, 1'b0, 8'd1), "recover_rep1_with_req");
        drive(1'b1, 3'b100, 4);
        drive(1'b0, 3'b100, 6);
        do_reset("reset_mid_recover");

        // 6c: a second replica going bad during recovery -> FAILSAFE.
        enter_tmr(3'b000, 3'b000, 8'd0);
        push_exp(4, mk(1'b1, 3'b111, 3'b100, 3'b000, 1'b0, 8'd1), "recover_rep1");
        drive(1'b0, 3'b100, 4);
        push_exp(4, mk(1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 8'd1), "nontarget_in_recover");
        drive(1'b0, 3'b010, 4);
        drive(1'b0, 3'b000, 3);

        chk_end = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
